prog_mem_loader: RTL and testbench
==================================

// Module: prog_mem_loader
// PURPOSE
//   Writable, parametrised YASAC code memory: a 2**ADDR_W x DATA_W instruction store with
//   a registered fetch port for the control unit and a byte-stream loader that writes a
//   program at run time. Supersedes the fixed, initial-block-only code ROM. The CPU is
//   held off (instr_valid=0) while a load is in progress.
// PARAMETERS
//   ADDR_W  8   fetch/write address width; DEPTH = 2**ADDR_W words
//   DATA_W  16  instruction width; must be a multiple of 8 (BYTES = DATA_W/8)
// PORTS
//   clk         in   1         system clock, all state changes on rising edge
//   reset       in   1         synchronous, active-high reset
//   load_start  in   1         start a load session (sampled in IDLE only)
//   load_len    in   ADDR_W+1  number of words to load, latched on load_start
//   ld_data     in   8         loader byte, most significant byte of each word first
//   ld_valid    in   1         ld_data valid
//   ld_ready    out  1         loader can accept a byte
//   loading     out  1         load session in progress
//   load_done   out  1         one-cycle pulse: session finished
//   fetch_en    in   1         fetch request
//   fetch_addr  in   ADDR_W    instruction address
//   instr       out  DATA_W    fetched instruction
//   instr_valid out  1         instr updated by the previous cycle's fetch
// BEHAVIOUR
//   Reset: state=IDLE; ld_ready=0, loading=0, load_done=0, instr=0, instr_valid=0,
//     wr_addr=0, byte counter=0, assembly reg=0. Memory contents are NOT cleared by reset
//     (zero at time 0 for simulation/synthesis init).
//   FSM: IDLE, LOAD, DONE.
//   IDLE: load_start=1 latches len = min(load_len, DEPTH), clears wr_addr and counters.
//     len!=0 -> LOAD; len==0 -> DONE (no writes).
//   LOAD: loading=1, ld_ready=1. Byte accepted when ld_valid && ld_ready; shifted into the
//     assembly register (MSB first). On the BYTES-th byte of a word, the word
//     {assembly, ld_data} is written to mem[wr_addr] on that same edge; wr_addr++,
//     byte counter back to 0. After the len-th word is written -> DONE.
//     ld_valid=0 stalls with no state change. load_start is ignored outside IDLE.
//   DONE: one cycle; load_done=1, loading=0, ld_ready=0 -> IDLE.
//   Fetch: 1-cycle latency. On an edge with fetch_en=1 and state==IDLE:
//     instr <= mem[fetch_addr], instr_valid <= 1. Otherwise instr_valid <= 0 and instr holds.
//     A fetch in the same cycle as load_start is served; the load starts on the same edge.
//     Read-during-write is impossible because fetch is blocked in LOAD and DONE.
//   Width: wr_addr is ADDR_W bits; len saturates at DEPTH, so no wrap during a load.
//   Reset mid-load: -> IDLE at once; partial word discarded; fully written words are
//     retained; no load_done pulse.
// TESTING
//   1 reset, then fetch addr 0x00..0x03 -> instr=0, instr_valid high 1 cycle after each fetch_en
//   2 load_len=3, bytes 08 07 00 01 10 05 -> mem[0..2]=0x0807,0x0001,0x1005; load_done
//     pulses 1 cycle after the 6th byte; fetch 2 -> 0x1005
//   3 same load with ld_valid toggling 1/0 every cycle -> same memory contents, no byte lost
//   4 load_len=0 -> load_done next cycle, loading never 1, memory unchanged
//   5 load_len=2^ADDR_W+5 -> exactly DEPTH words written, last at 0xFF, then DONE
//   6 reset after 3 bytes of a 2-word load -> mem[0] new, mem[1] old, load_done stays 0

Source files
------------

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: writable 2**ADDR_W x DATA_W instruction store.
// A registered fetch port serves the control unit while idle; a byte-stream
// loader (most significant byte of each word first) writes a program at run
// time. Fetches are refused while a load session is active, so the CPU sees
// instr_valid=0 until the program is in place.
module prog_mem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_load_start,
    input  logic [ADDR_W:0]   i_load_len,
    input  logic [7:0]        i_ld_data,
    input  logic              i_ld_valid,
    output logic              o_ld_ready,
    output logic              o_loading,
    output logic              o_load_done,
    input  logic              i_fetch_en,
    input  logic [ADDR_W-1:0] i_fetch_addr,
    output logic [DATA_W-1:0] o_instr,
    output logic              o_instr_valid
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int BYTES = DATA_W / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next_state;

    logic [ADDR_W:0]     r_len;        // words in this session, saturated at DEPTH
    logic [ADDR_W-1:0]   r_wr_addr;    // next word address to write
    logic [CNT_W-1:0]    r_byte_cnt;   // bytes already collected for the current word
    logic [DATA_W-1:0]   r_asm;        // partial word, earlier bytes in the upper bits

    // Instruction store; starts at zero and is never cleared by reset, so a
    // program survives a CPU reset.
    logic [DATA_W-1:0]   r_mem [DEPTH] = '{default: '0};

    logic [ADDR_W:0]     w_len_sat;
    logic                w_accept;
    logic                w_byte_last;
    logic                w_word_last;
    logic                w_wr_en;
    logic [DATA_W-1:0]   w_word;
    logic                w_fetch;

    // Requested length clipped to the memory size, so wr_addr never wraps.
    assign w_len_sat   = (i_load_len > (ADDR_W+1)'(DEPTH)) ? (ADDR_W+1)'(DEPTH) : i_load_len;
    assign w_accept    = i_ld_valid && o_ld_ready;
    assign w_byte_last = (r_byte_cnt == CNT_W'(BYTES - 1));
    assign w_word_last = ({1'b0, r_wr_addr} == (r_len - (ADDR_W+1)'(1)));
    assign w_wr_en     = w_accept && w_byte_last;
    // Shift the incoming byte in below the bytes already collected.
    assign w_word      = (r_asm << 8) | DATA_W'(i_ld_data);
    assign w_fetch     = i_fetch_en && (r_state == S_IDLE);

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of block ordering.
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived handshake outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves one unassigned and no latch is inferred.
        w_next_state = r_state;
        o_ld_ready   = 1'b0;
        o_loading    = 1'b0;
        o_load_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load_start) begin
                    w_next_state = (w_len_sat == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                o_ld_ready = 1'b1;
                o_loading  = 1'b1;
                if (w_wr_en && w_word_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                o_load_done  = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Loader datapath: session length, write pointer, byte assembly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_len      <= '0;
            r_wr_addr  <= '0;
            r_byte_cnt <= '0;
            r_asm      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_load_start) begin
                        r_len      <= w_len_sat;
                        r_wr_addr  <= '0;
                        r_byte_cnt <= '0;
                        r_asm      <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        if (w_byte_last) begin
                            r_wr_addr  <= r_wr_addr + ADDR_W'(1);
                            r_byte_cnt <= '0;
                            r_asm      <= '0;
                        end else begin
                            r_byte_cnt <= r_byte_cnt + CNT_W'(1);
                            r_asm      <= w_word;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory write port: the completed word lands on the edge of its last byte.
    always_ff @(posedge i_clk) begin
        // NOTE: the array has no reset branch; clearing a RAM would need a
        // per-word sweep and would destroy a loaded program on CPU reset.
        if (w_wr_en) begin
            r_mem[r_wr_addr] <= w_word;
        end
    end

    // Registered fetch port, only served while idle; instr holds otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_instr       <= '0;
            o_instr_valid <= 1'b0;
        end else if (w_fetch) begin
            o_instr       <= r_mem[i_fetch_addr];
            o_instr_valid <= 1'b1;
        end else begin
            o_instr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_prog_mem_loader.sv
// tb_prog_mem_loader: directed stimulus against a session-level model of the
// loader (byte queue packed into words, word countdown) plus a flat memory
// array. A compare process checks every handshake/fetch output each cycle;
// literal expectations pin the model at key points.
module tb_prog_mem_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int BYTES  = DATA_W / 8;

    logic              i_clk = 1'b0;
    logic              i_reset;
    logic              i_load_start;
    logic [ADDR_W:0]   i_load_len;
    logic [7:0]        i_ld_data;
    logic              i_ld_valid;
    logic              o_ld_ready;
    logic              o_loading;
    logic              o_load_done;
    logic              i_fetch_en;
    logic [ADDR_W-1:0] i_fetch_addr;
    logic [DATA_W-1:0] o_instr;
    logic              o_instr_valid;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic [7:0] byte_q [$];

    prog_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load_start (i_load_start),
        .i_load_len   (i_load_len),
        .i_ld_data    (i_ld_data),
        .i_ld_valid   (i_ld_valid),
        .o_ld_ready   (o_ld_ready),
        .o_loading    (o_loading),
        .o_load_done  (o_load_done),
        .i_fetch_en   (i_fetch_en),
        .i_fetch_addr (i_fetch_addr),
        .o_instr      (o_instr),
        .o_instr_valid(o_instr_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [7:0]        m_bytes [$];
    bit                m_session = 1'b0;   // words still expected from the stream
    bit                m_done    = 1'b0;   // completion pulse visible this cycle
    int                m_left    = 0;
    int                m_wr      = 0;
    logic [DATA_W-1:0] m_instr   = '0;
    bit                m_valid   = 1'b0;

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    end

    always @(posedge i_clk) begin
        bit               idle_before;
        bit               new_done;
        int               n;
        logic [DATA_W-1:0] w;
        if (i_reset) begin
            m_session = 1'b0;
            m_done    = 1'b0;
            m_instr   = '0;
            m_valid   = 1'b0;
            m_bytes.delete();
        end else begin
            idle_before = !m_session && !m_done;
            new_done    = 1'b0;
            if (idle_before && i_fetch_en) begin
                m_instr = model_mem[i_fetch_addr];
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (m_session) begin
                if (i_ld_valid) begin
                    m_bytes.push_back(i_ld_data);
                    if (m_bytes.size() == BYTES) begin
                        w = '0;
                        foreach (m_bytes[k]) w = (w << 8) | DATA_W'(m_bytes[k]);
                        model_mem[m_wr] = w;
                        m_wr++;
                        m_bytes.delete();
                        m_left--;
                        if (m_left == 0) begin
                            m_session = 1'b0;
                            new_done  = 1'b1;
                        end
                    end
                end
            end else if (idle_before && i_load_start) begin
                n = (int'(i_load_len) > DEPTH) ? DEPTH : int'(i_load_len);
                m_left = n;
                m_wr   = 0;
                m_bytes.delete();
                if (n == 0) new_done = 1'b1;
                else        m_session = 1'b1;
            end
            m_done = new_done;
        end
    end

    // Per-cycle comparison, away from the active edge.
    always @(negedge i_clk) begin
        if (chk_en) begin
            check("loading",     {31'd0, o_loading},     {31'd0, m_session});
            check("ld_ready",    {31'd0, o_ld_ready},    {31'd0, m_session});
            check("load_done",   {31'd0, o_load_done},   {31'd0, m_done});
            check("instr_valid", {31'd0, o_instr_valid}, {31'd0, m_valid});
            check("instr",       32'(o_instr),           32'(m_instr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic fetch(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp, input string name);
        i_fetch_en   = 1'b1;
        i_fetch_addr = a;
        step();
        i_fetch_en   = 1'b0;
        check(name, 32'(o_instr), 32'(exp));
        check({name, "_valid"}, {31'd0, o_instr_valid}, 32'd1);
    endtask

    // Start a session and stream byte_q; optional idle cycle after each byte.
    task automatic do_load(input logic [ADDR_W:0] len, input bit gaps, input string name);
        i_load_start = 1'b1;
        i_load_len   = len;
        step();
        i_load_start = 1'b0;
        foreach (byte_q[i]) begin
            i_ld_valid = 1'b1;
            i_ld_data  = byte_q[i];
            step();
            if (i == byte_q.size() - 1)
                check({name, "_done_pulse"}, {31'd0, o_load_done}, 32'd1);
            if (gaps) begin
                i_ld_valid = 1'b0;
                i_ld_data  = 8'hEE;
                step();
            end
        end
        i_ld_valid = 1'b0;
        step();
        check({name, "_done_cleared"}, {31'd0, o_load_done}, 32'd0);
    endtask

    initial begin
        i_reset      = 1'b1;
        i_load_start = 1'b0;
        i_load_len   = '0;
        i_ld_data    = '0;
        i_ld_valid   = 1'b0;
        i_fetch_en   = 1'b0;
        i_fetch_addr = '0;
        step();
        chk_en = 1'b1;
        step();
        check("reset_instr", 32'(o_instr), 32'd0);
        check("reset_ready", {31'd0, o_ld_ready}, 32'd0);
        i_reset = 1'b0;

        // 1: fetches of an unloaded memory
        for (int a = 0; a < 4; a++) fetch(ADDR_W'(a), 16'h0000, "t1_fetch");
        step();

        // 2: three-word load, continuous stream
        byte_q = '{8'h08, 8'h07, 8'h00, 8'h01, 8'h10, 8'h05};
        do_load(9'd3, 1'b0, "t2");
        fetch(8'd2, 16'h1005, "t2_fetch2");
        fetch(8'd0, 16'h0807, "t2_fetch0");
        fetch(8'd1, 16'h0001, "t2_fetch1");

        // 3: same load with gaps; fetch held high to show it is blocked mid-load
        i_fetch_en   = 1'b1;
        i_fetch_addr = 8'd2;
        do_load(9'd3, 1'b1, "t3");
        i_fetch_en   = 1'b0;
        fetch(8'd0, 16'h0807, "t3_fetch0");
        fetch(8'd1, 16'h0001, "t3_fetch1");
        fetch(8'd2, 16'h1005, "t3_fetch2");

        // 4: zero-length load together with a fetch on the same edge
        i_load_start = 1'b1;
        i_load_len   = 9'd0;
        i_fetch_en   = 1'b1;
        i_fetch_addr = 8'd1;
        step();
        i_load_start = 1'b0;
        i_fetch_en   = 1'b0;
        check("t4_done", {31'd0, o_load_done}, 32'd1);
        check("t4_loading", {31'd0, o_loading}, 32'd0);
        check("t4_same_edge_fetch", 32'(o_instr), 32'h0001);
        step();
        check("t4_done_cleared", {31'd0, o_load_done}, 32'd0);
        fetch(8'd0, 16'h0807, "t4_fetch0");

        // 5: oversized length saturates at DEPTH; word k = {k^A5, k}
        byte_q.delete();
        for (int k = 0; k < DEPTH; k++) begin
            byte_q.push_back(8'(k) ^ 8'hA5);
            byte_q.push_back(8'(k));
        end
        do_load(9'(DEPTH + 5), 1'b0, "t5");
        fetch(8'hFF, 16'h5AFF, "t5_fetch_ff");
        fetch(8'h00, 16'hA500, "t5_fetch_00");
        fetch(8'h02, 16'hA702, "t5_fetch_02");

        // 6: reset after three bytes of a two-word load
        i_load_start = 1'b1;
        i_load_len   = 9'd2;
        step();
        i_load_start = 1'b0;
        i_ld_valid   = 1'b1;
        foreach (byte_q[i]) if (i < 0) i_ld_data = 8'h00;  // keep queue intact
        i_ld_data = 8'h12; step();
        i_ld_data = 8'h34; step();
        i_ld_data = 8'h56; step();
        i_ld_valid = 1'b0;
        i_reset    = 1'b1;
        step();
        check("t6_done_low", {31'd0, o_load_done}, 32'd0);
        check("t6_loading_low", {31'd0, o_loading}, 32'd0);
        i_reset = 1'b0;
        step();
        fetch(8'd0, 16'h1234, "t6_fetch0");
        fetch(8'd1, 16'hA401, "t6_fetch1");
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
